io_bus_memory_responder: RTL and testbench
==========================================

// Module: io_bus_memory_responder
// PURPOSE
//  Responder at the far end of the 8-bit CPU I/O pin bus. Holds instruction and data memory.
//  Serves 32-bit instruction words and load data byte-serially, LSB first.
//  Captures byte-serial address/data words for stores, loads and jump/branch targets.
//  Sits off-chip in the companion FPGA or the bench, wired pin-for-pin to the CPU-side I/O controller.
// PARAMETERS
//  IMEM_WORDS  64     instruction memory depth, 32-bit words, power of 2
//  DMEM_WORDS  64     data memory depth, 32-bit words, power of 2
//  RESET_PC    32'h0  fetch address loaded on reset
// PORTS
//  clk         in   1   single clock, all logic on posedge
//  rst         in   1   synchronous reset, active-high
//  io_phase    in   2   bus phase: 00 IDLE, 01 FETCH, 10 WORD, 11 READ
//  io_op       in   2   sampled on first WORD cycle: 00 STORE, 01 LOAD, 10 JUMP, 11 reserved
//  addr_in     in   8   address byte from CPU side
//  data_in     in   8   store-data byte from CPU side
//  data_out    out  8   byte to CPU side (instruction or load data)
//  ld_en       in   1   preload strobe, honoured only in IDLE
//  ld_sel      in   1   preload target: 0 imem, 1 dmem
//  ld_addr     in   8   preload word index; upper bits ignored
//  ld_data     in   32  preload word
//  pc_out      out  32  current fetch byte address
//  fetch_count out  16  completed fetches, saturates at 16'hFFFF
//  proto_err   out  1   sticky protocol-violation flag
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - data_out=0, pc_out=RESET_PC, fetch_count=0, proto_err=0.
//   - byte_cnt=0, load_pending=0, shift regs cleared. Memory contents are not cleared.
//   - Reset mid-transaction aborts it; no memory or pc update.
//  byte_cnt (3 bit):
//   - Clears when io_phase differs from the previous cycle's phase.
//   - Otherwise increments each cycle while phase!=IDLE; saturates at 4.
//  data_out: combinational from phase, byte_cnt and the source word.
//  FETCH: in FETCH cycle k (k=0..3), data_out=imem[pc_out[IA+1:2]][8k+:8]; zero-latency, same cycle.
//   - On the 4th byte's posedge: pc_out += 4 (wraps modulo 4*IMEM_WORDS), fetch_count++.
//  WORD:
//   - In cycle k, addr_sr[8k+:8] <= addr_in and data_sr[8k+:8] <= data_in.
//   - io_op is latched in cycle 0.
//   - The 4th byte's posedge commits:
//     STORE: dmem[addr[DA+1:2]] <= {data_in, data_sr[23:0]}.
//     LOAD: rd_word <= dmem[...] and load_pending <= 1.
//     JUMP: pc_out <= {addr_in, addr_sr[23:0]} & ~3.
//   - Reserved op: no commit; proto_err set.
//   - data_out=0 throughout WORD.
//  READ:
//   - With load_pending=1: data_out=rd_word[8k+:8] for k=0..3.
//   - load_pending clears on the 4th byte.
//   - READ with load_pending=0: data_out=0, proto_err set.
//  Address bits [1:0] are ignored. Out-of-range indices wrap (upper bits ignored).
//  Boundary cases:
//   - Phase held past 4 cycles (byte_cnt==4, phase!=IDLE): data_out=0, no further commits, proto_err set.
//   - Phase change before the 4th byte: partial transaction discarded, no commit, proto_err set.
//   - STORE then LOAD to the same word back-to-back: LOAD returns the new value; write is visible next cycle.
//   - ld_en in IDLE: mem[ld_addr] <= ld_data next posedge.
//   - ld_en while phase!=IDLE: ignored, proto_err set.
//  proto_err clears only on rst.
// TESTING
//  1. Preload imem[0]=32'hDEADBEEF, four FETCH cycles -> data_out EF,BE,AD,DE; then pc_out=4, fetch_count=1.
//  2. WORD STORE addr=32'h10, data=32'hCAFEF00D; then WORD LOAD addr=32'h10 and READ x4 -> data_out 0D,F0,FE,CA; proto_err=0.
//  3. WORD JUMP addr=32'h0000_0023 -> pc_out=32'h20; next FETCH returns imem[8].
//  4. pc_out=4*IMEM_WORDS-4, one FETCH -> pc_out wraps to 0.
//  5. FETCH held 6 cycles -> cycles 4,5 data_out=0, fetch_count +1 only, proto_err=1.
//     READ with no pending load -> data_out=0, proto_err=1.
//  6. rst=1 at WORD cycle 2 of a STORE -> dmem unchanged, pc_out=RESET_PC, all outputs at reset values next cycle.

Source files
------------

// File: rtl/io_bus_memory_responder.sv
// Far-end responder for the 8-bit CPU I/O pin bus: instruction and data
// memory, byte-serial instruction/load-data delivery (LSB first), and
// byte-serial capture of store/load/jump address and data words.
module io_bus_memory_responder #(
  parameter int          IMEM_WORDS = 64,
  parameter int          DMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  io_phase,
  input  logic [1:0]  io_op,
  input  logic [7:0]  addr_in,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic        ld_en,
  input  logic        ld_sel,
  input  logic [7:0]  ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] pc_out,
  output logic [15:0] fetch_count,
  output logic        proto_err
);

  localparam int          IA      = $clog2(IMEM_WORDS);
  localparam int          DA      = $clog2(DMEM_WORDS);
  localparam logic [31:0] PC_MASK = 32'(4 * IMEM_WORDS - 1);

  typedef enum logic [1:0] {
    PH_IDLE  = 2'b00,
    PH_FETCH = 2'b01,
    PH_WORD  = 2'b10,
    PH_READ  = 2'b11
  } phase_t;

  typedef enum logic [1:0] {
    OP_STORE = 2'b00,
    OP_LOAD  = 2'b01,
    OP_JUMP  = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  phase_t      phase, prev_phase;
  op_t         op_r;
  logic [2:0]  byte_cnt, byte_cnt_nxt, k;
  logic [23:0] addr_sr, data_sr;
  logic [31:0] rd_word, fetch_word, word_addr, word_data;
  logic        load_pending;
  logic        active, last, abort, overrun, err_set;
  logic        fetch_done, word_done, read_done, ld_ok;
  logic        unused_bits;

  assign phase      = phase_t'(io_phase);
  assign fetch_word = imem[pc_out[IA+1:2]];
  assign word_addr  = {addr_in, addr_sr};
  assign word_data  = {data_in, data_sr};
  assign unused_bits = ^{ld_addr, word_addr[31:DA+2], word_addr[1:0]};

  // Byte index of the current cycle, transaction boundaries and error sources.
  // The index is forced to 0 on a phase change so byte 0 is served in the
  // very first cycle of a phase even though the counter is registered.
  always_comb begin
    k            = (phase != prev_phase) ? 3'd0 : byte_cnt;
    active       = (phase != PH_IDLE) && (k != 3'd4);
    last         = active && (k == 3'd3);
    overrun      = (phase != PH_IDLE) && (k == 3'd4);
    abort        = (phase != prev_phase) && (prev_phase != PH_IDLE) && (byte_cnt != 3'd4);
    fetch_done   = last && (phase == PH_FETCH);
    word_done    = last && (phase == PH_WORD);
    read_done    = last && (phase == PH_READ) && load_pending;
    ld_ok        = ld_en && (phase == PH_IDLE);
    byte_cnt_nxt = '0;
    if (phase != PH_IDLE)
      byte_cnt_nxt = (k == 3'd4) ? 3'd4 : k + 3'd1;
    err_set = abort || overrun
           || (ld_en && (phase != PH_IDLE))
           || (word_done && (op_r == OP_RSVD))
           || ((phase == PH_READ) && active && !load_pending);
  end

  // Byte returned to the CPU side, selected by phase and byte index.
  always_comb begin
    data_out = '0;
    if (active && (phase == PH_FETCH))
      data_out = fetch_word[{k[1:0], 3'b000} +: 8];
    else if (active && (phase == PH_READ) && load_pending)
      data_out = rd_word[{k[1:0], 3'b000} +: 8];
  end

  // Phase tracking, word capture, commits and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_phase   <= PH_IDLE;
      byte_cnt     <= '0;
      op_r         <= OP_STORE;
      addr_sr      <= '0;
      data_sr      <= '0;
      rd_word      <= '0;
      load_pending <= 1'b0;
      pc_out       <= RESET_PC;
      fetch_count  <= '0;
      proto_err    <= 1'b0;
    end else begin
      prev_phase <= phase;
      byte_cnt   <= byte_cnt_nxt;
      if (err_set)
        proto_err <= 1'b1;
      if (active && (phase == PH_WORD)) begin
        if (k == 3'd0)
          op_r <= op_t'(io_op);
        if (k != 3'd3) begin
          addr_sr[{k[1:0], 3'b000} +: 8] <= addr_in;
          data_sr[{k[1:0], 3'b000} +: 8] <= data_in;
        end
      end
      if (fetch_done) begin
        pc_out <= (pc_out + 32'd4) & PC_MASK;
        if (fetch_count != 16'hFFFF)
          fetch_count <= fetch_count + 16'd1;
      end
      if (word_done && (op_r == OP_LOAD)) begin
        rd_word      <= dmem[word_addr[DA+1:2]];
        load_pending <= 1'b1;
      end
      if (word_done && (op_r == OP_JUMP))
        pc_out <= word_addr & ~32'd3;
      if (read_done)
        load_pending <= 1'b0;
    end
  end

  // Memory writes: preload in IDLE and STORE commits; never under reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (ld_ok && !ld_sel)
        imem[ld_addr[IA-1:0]] <= ld_data;
      if (ld_ok && ld_sel)
        dmem[ld_addr[DA-1:0]] <= ld_data;
      if (word_done && (op_r == OP_STORE))
        dmem[word_addr[DA+1:2]] <= word_data;
    end
  end

endmodule

// File: tb/tb_io_bus_memory_responder.sv
// Bench for io_bus_memory_responder: transaction-level model of memories,
// pc, fetch counter, pending load and sticky error; one compare process.
module tb_io_bus_memory_responder;

  localparam int IW = 64;
  localparam int DW = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  io_phase, io_op;
  logic [7:0]  addr_in, data_in, data_out, ld_addr;
  logic        ld_en, ld_sel;
  logic [31:0] ld_data, pc_out;
  logic [15:0] fetch_count;
  logic        proto_err;

  io_bus_memory_responder #(.IMEM_WORDS(IW), .DMEM_WORDS(DW), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .io_phase(io_phase), .io_op(io_op),
    .addr_in(addr_in), .data_in(data_in), .data_out(data_out),
    .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .pc_out(pc_out), .fetch_count(fetch_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Model state
  logic [31:0] m_imem [IW];
  logic [31:0] m_dmem [DW];
  logic [31:0] m_pc, m_rd;
  int unsigned m_cnt;
  bit          m_err, m_pend, abort_pend;
  logic [7:0]  exp_dout;
  logic [7:0]  blog [4];
  bit          chk_en = 1'b0;

  // Literal pin requests handed to the compare process
  string       lit_name;
  logic [31:0] lit_act, lit_exp;
  bit          lit_go = 1'b0, lit_seen = 1'b0;

  int n_cmp = 0, n_bad = 0;

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Single compare process, mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("data_out", {24'h0, data_out}, {24'h0, exp_dout});
      cmp("pc_out", pc_out, m_pc);
      cmp("fetch_count", {16'h0, fetch_count}, m_cnt);
      cmp("proto_err", {31'h0, proto_err}, {31'h0, m_err});
      if (lit_go != lit_seen) begin
        lit_seen = lit_go;
        cmp(lit_name, lit_act, lit_exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (abort_pend) m_err = 1'b1;
    abort_pend = 1'b0;
  endtask

  task automatic drive_idle();
    io_phase = 2'b00; io_op = 2'($urandom); addr_in = 8'($urandom); data_in = 8'($urandom);
    ld_en = 1'b0; ld_sel = 1'b0; ld_addr = 8'($urandom); ld_data = $urandom;
    exp_dout = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive_idle();
      step();
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    lit_name = name; lit_act = act; lit_exp = exp;
    lit_go = ~lit_go;
    idle(1);
  endtask

  task automatic preload(input bit sel, input logic [7:0] a, input logic [31:0] w);
    drive_idle();
    ld_en = 1'b1; ld_sel = sel; ld_addr = a; ld_data = w;
    step();
    if (sel) m_dmem[int'(a) % DW] = w;
    else     m_imem[int'(a) % IW] = w;
    ld_en = 1'b0;
  endtask

  task automatic fetch(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      drive_idle();
      io_phase = 2'b01;
      w = m_imem[int'(m_pc >> 2) % IW];
      exp_dout = (i < 4) ? w[8*i +: 8] : 8'h00;
      if (i < 4) blog[i] = exp_dout;
      step();
      if (i == 3) begin
        m_pc = (m_pc + 32'd4) & 32'(4 * IW - 1);
        if (m_cnt < 32'hFFFF) m_cnt++;
      end
      if (i >= 4) m_err = 1'b1;
    end
    if (n < 4) abort_pend = 1'b1;
  endtask

  task automatic word(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                      input int n, input bit bad_ld);
    for (int i = 0; i < n; i++) begin
      drive_idle();
      io_phase = 2'b10;
      if (i == 0) io_op = op;
      if (i < 4) begin
        addr_in = a[8*i +: 8];
        data_in = d[8*i +: 8];
      end
      if (bad_ld && i == 1) begin
        ld_en = 1'b1; ld_sel = 1'($urandom);
      end
      step();
      if (bad_ld && i == 1) m_err = 1'b1;
      if (i == 3) begin
        case (op)
          2'b00: m_dmem[int'(a >> 2) % DW] = d;
          2'b01: begin m_rd = m_dmem[int'(a >> 2) % DW]; m_pend = 1'b1; end
          2'b10: m_pc = a & ~32'd3;
          default: m_err = 1'b1;
        endcase
      end
      if (i >= 4) m_err = 1'b1;
    end
    if (n < 4) abort_pend = 1'b1;
  endtask

  task automatic read(input int n);
    for (int i = 0; i < n; i++) begin
      drive_idle();
      io_phase = 2'b11;
      exp_dout = (i < 4 && m_pend) ? m_rd[8*i +: 8] : 8'h00;
      if (i < 4) blog[i] = exp_dout;
      step();
      if (i < 4 && !m_pend) m_err = 1'b1;
      if (i == 3) m_pend = 1'b0;
      if (i >= 4) m_err = 1'b1;
    end
    if (n < 4) abort_pend = 1'b1;
  endtask

  task automatic reset_cycle(input logic [1:0] ph);
    drive_idle();
    io_phase = ph;
    chk_en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_pc = 32'h0; m_cnt = 0; m_err = 1'b0; m_pend = 1'b0; m_rd = '0; abort_pend = 1'b0;
    drive_idle();
    chk_en = 1'b1;
  endtask

  function automatic logic [31:0] blog_word();
    return {blog[3], blog[2], blog[1], blog[0]};
  endfunction

  initial begin
    int n, r;
    logic [1:0] op;
    rst = 1'b1;
    drive_idle();
    step();
    reset_cycle(2'b00);
    idle(1);
    for (int i = 0; i < IW; i++) preload(1'b0, 8'(i), $urandom);
    for (int i = 0; i < DW; i++) preload(1'b1, 8'(i), $urandom);
    idle(1);

    // Directed: fetch of a preloaded word
    preload(1'b0, 8'd0, 32'hDEADBEEF);
    idle(1);
    fetch(4);
    idle(1);
    lit("t1_bytes", blog_word(), 32'hDEADBEEF);
    lit("t1_pc", m_pc, 32'd4);
    lit("t1_cnt", m_cnt, 32'd1);

    // Store then load the same word, read back
    word(2'b00, 32'h10, 32'hCAFEF00D, 4, 1'b0);
    idle(1);
    word(2'b01, 32'h10, 32'h0, 4, 1'b0);
    read(4);
    idle(1);
    lit("t2_bytes", blog_word(), 32'hCAFEF00D);
    lit("t2_err", {31'h0, m_err}, 32'd0);

    // Jump with misaligned target, then fetch from imem[8]
    preload(1'b0, 8'd8, 32'h12345678);
    word(2'b10, 32'h0000_0023, 32'h0, 4, 1'b0);
    idle(1);
    lit("t3_pc", m_pc, 32'h20);
    fetch(4);
    idle(1);
    lit("t3_bytes", blog_word(), 32'h12345678);

    // PC wrap at the top of imem
    word(2'b10, 32'(4 * IW - 4), 32'h0, 4, 1'b0);
    idle(1);
    fetch(4);
    idle(1);
    lit("t4_pc", m_pc, 32'h0);

    // Over-held fetch, then read with nothing pending
    fetch(6);
    idle(1);
    lit("t5_cnt", m_cnt, 32'd4);
    lit("t5_err", {31'h0, m_err}, 32'd1);
    reset_cycle(2'b00);
    idle(1);
    read(4);
    idle(1);
    lit("t5_rd_bytes", blog_word(), 32'h0);
    lit("t5_rd_err", {31'h0, m_err}, 32'd1);

    // Reset in the middle of a store
    reset_cycle(2'b00);
    preload(1'b1, 8'd5, 32'h0BADF00D);
    word(2'b10, 32'h40, 32'h0, 4, 1'b0);
    idle(1);
    word(2'b00, 32'h14, 32'h11111111, 2, 1'b0);
    reset_cycle(2'b10);
    idle(1);
    lit("t6_pc", m_pc, 32'h0);
    word(2'b01, 32'h14, 32'h0, 4, 1'b0);
    idle(1);
    read(4);
    idle(1);
    lit("t6_bytes", blog_word(), 32'h0BADF00D);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      if (t % 30 == 29) begin
        reset_cycle(2'($urandom));
        idle(1);
      end
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6)) : 4;
      r = int'($urandom_range(0, 9));
      case (r)
        0: preload(1'($urandom), 8'($urandom), $urandom);
        1, 2: fetch(n);
        3, 4, 5: begin
          op = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
          word(op, $urandom, $urandom, n, (n >= 2) && ($urandom_range(0, 15) == 0));
        end
        6, 7: read(n);
        default: idle(1);
      endcase
      idle(1);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
